// File: rtl/piso_pkg.sv
// Shared constants and helpers for the parallel-in serial-out shifter.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
package piso_pkg;

`ifdef PISO_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  typedef enum logic {
    ORDER_LSB = 1'b0,
    ORDER_MSB = 1'b1
  } bit_order_e;

  function automatic int cnt_w(input int width);
    return $clog2(width + 2);
  endfunction

  function automatic int frame_len(input int width);
    return width + PAR_BITS;
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter tracking bits left in the frame.
// Produces busy (bits pending) and done (last bit on the line).
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic busy_o,
  output logic done_o
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] FRAME = CW'(frame_len(WIDTH));
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count includes the bit currently on dout; saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = FRAME;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);
  assign done_o = (cnt_q == ONE);

endmodule

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shifter, one bit per clock on dout.
// Optional even parity bit appended when PISO_PARITY_EN is defined.
module piso_shift_reg
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             latch,
  input  logic [WIDTH-1:0] din,
  output logic             dout,
  output logic             busy,
  output logic             done
);

  localparam int FW = frame_len(WIDTH);
  localparam bit_order_e ORDER =
    MSB_FIRST ? ORDER_MSB : ORDER_LSB;

  logic [FW-1:0] sr_q;
  logic [FW-1:0] sr_d;
  logic [FW-1:0] frame_w;
  logic          head_w;

  // Parity rides at the tail of the frame in send order.
  generate
    if (ORDER == ORDER_MSB) begin : g_msb
`ifdef PISO_PARITY_EN
      assign frame_w = {din, ^din};
`else
      assign frame_w = din;
`endif
      assign head_w = sr_q[FW-1];
    end else begin : g_lsb
`ifdef PISO_PARITY_EN
      assign frame_w = {^din, din};
`else
      assign frame_w = din;
`endif
      assign head_w = sr_q[0];
    end
  endgenerate

  piso_bit_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (latch),
    .busy_o (busy),
    .done_o (done)
  );

  always_comb begin
    sr_d = sr_q;
    if (latch) begin
      sr_d = frame_w;
    end else if (busy) begin
      if (ORDER == ORDER_MSB) begin
        sr_d = sr_q << 1;
      end else begin
        sr_d = sr_q >> 1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign dout = busy & head_w;

endmodule

// File: tb/tb_piso_shift_reg.sv
// Directed bench for piso_shift_reg, MSB-first and LSB-first lanes.
// Frame length follows PISO_PARITY_EN.
module tb_piso_shift_reg;

`ifdef PISO_PARITY_EN
  localparam int N = 9;
`else
  localparam int N = 8;
`endif

  logic       clk;
  logic       rst;
  logic       latch;
  logic [7:0] din;
  logic       m_dout, m_busy, m_done;
  logic       l_dout, l_busy, l_done;

  int vectors = 0;
  int errors  = 0;

  piso_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk   (clk),
    .rst   (rst),
    .latch (latch),
    .din   (din),
    .dout  (m_dout),
    .busy  (m_busy),
    .done  (m_done)
  );

  piso_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk   (clk),
    .rst   (rst),
    .latch (latch),
    .din   (din),
    .dout  (l_dout),
    .busy  (l_busy),
    .done  (l_done)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".m_dout"}, m_dout, 1'b0);
    chk({tag, ".m_busy"}, m_busy, 1'b0);
    chk({tag, ".m_done"}, m_done, 1'b0);
    chk({tag, ".l_dout"}, l_dout, 1'b0);
    chk({tag, ".l_busy"}, l_busy, 1'b0);
    chk({tag, ".l_done"}, l_done, 1'b0);
  endtask

  task automatic chk_cyc(input string tag, input int k,
                         input logic em, input logic el);
    string t;
    t = $sformatf("%s.k%0d", tag, k);
    chk({t, ".m_dout"}, m_dout, em);
    chk({t, ".l_dout"}, l_dout, el);
    chk({t, ".m_busy"}, m_busy, 1'b1);
    chk({t, ".l_busy"}, l_busy, 1'b1);
    chk({t, ".m_done"}, m_done, k == N - 1);
    chk({t, ".l_done"}, l_done, k == N - 1);
  endtask

  // sm/sl: hand-computed send order, bit k = k-th bit on the line.
  task automatic send(input string tag, input logic [7:0] w,
                      input logic [8:0] sm, input logic [8:0] sl);
    din   = w;
    latch = 1'b1;
    tick();
    latch = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk_cyc(tag, k, sm[k], sl[k]);
      tick();
    end
    chk_idle({tag, ".after"});
  endtask

  initial begin
    rst   = 1'b0;
    latch = 1'b0;
    din   = 8'h00;

    #2;
    chk_idle("rst.t2");
    #9;
    chk_idle("rst.t11");
    #4;
    rst = 1'b1;
    #1;
    chk_idle("rst.release");
    tick();
    chk_idle("rst.idle");

    // 8'hAA: MSB 1,0,1,0,... LSB 0,1,0,1,... parity 0
    send("aa", 8'hAA, 9'h055, 9'h0AA);

    // 8'h01: LSB 1 then zeros, parity 1
    send("x01", 8'h01, 9'h180, 9'h101);

    // Parity frames: 8'h07 parity 1, 8'h03 parity 0
    send("x07", 8'h07, 9'h1E0, 9'h107);
    send("x03", 8'h03, 9'h0C0, 9'h003);

    // Reload mid-word: FF for three bits, then 00
    din   = 8'hFF;
    latch = 1'b1;
    tick();
    latch = 1'b0;
    chk_cyc("rl.ff", 0, 1'b1, 1'b1);
    tick();
    chk_cyc("rl.ff", 1, 1'b1, 1'b1);
    tick();
    chk_cyc("rl.ff", 2, 1'b1, 1'b1);
    din   = 8'h00;
    latch = 1'b1;
    tick();
    latch = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk_cyc("rl.00", k, 1'b0, 1'b0);
      tick();
    end
    chk_idle("rl.after");

    // Latch held: reloads each edge, first bit stays up
    din   = 8'h81;
    latch = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold.m_dout", m_dout, 1'b1);
      chk("hold.l_dout", l_dout, 1'b1);
      chk("hold.m_done", m_done, 1'b0);
      chk("hold.m_busy", m_busy, 1'b1);
    end
    latch = 1'b0;
    tick();
    chk("hold.m_k1", m_dout, 1'b0);
    chk("hold.l_k1", l_dout, 1'b0);
    for (int k = 1; k < N; k++) tick();
    chk_idle("hold.after");

    // Reset asserted while bit 4 of 8'hAA is on the line
    din   = 8'hAA;
    latch = 1'b1;
    tick();
    latch = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("mr.m_bit4", m_dout, 1'b1);
    chk("mr.l_bit4", l_dout, 1'b0);
    chk("mr.m_busy", m_busy, 1'b1);
    rst = 1'b0;
    #1;
    chk_idle("mr.async");
    #3;
    rst = 1'b1;
    tick();
    chk_idle("mr.idle1");
    tick();
    chk_idle("mr.idle2");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
